set_mode_ctrl: RTL and testbench
================================

Name: set_mode_ctrl

Overview:
Sequences the clock's time-set datapath from debounced pushbutton events. Takes mode and adjust button events from the pushbutton debouncers and walks a RUN -> SET_HR -> SET_MIN -> RUN cycle. Issues single-cycle increment commands to the hour/minute trigger counters, with hold-to-auto-repeat, idle timeout and a blink enable for the selected field. Sits between the debouncers and the counters; the counters never see raw button levels.

Parameters:
HOLD_CYCLES, 50_000_000, cycles adj must stay held after its press before auto-repeat starts (1 s at 50 MHz)
REPEAT_CYCLES, 12_500_000, cycles between auto-repeat pulses while held
BLINK_CYCLES, 25_000_000, half-period of blink in set states
TIMEOUT_CYCLES, 500_000_000, idle cycles in a set state before automatic return to RUN

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
mode_down  input  1  one-cycle pulse: mode button pressed (debounced)
adj_state  input  1  debounced level of adjust button, 1 = held
adj_down  input  1  one-cycle pulse: adjust button pressed (debounced)
run_en  output  1  1 = timekeeping counters advance normally
inc_hr  output  1  one-cycle increment command to hour counter
inc_min  output  1  one-cycle increment command to minute counter
field_sel  output  2  00 RUN, 01 hour, 10 minute; 11 never driven
blink  output  1  display blank enable for selected field

Behaviour:
- All outputs registered. Reset (rst=1 at clk edge, any state): state RUN, run_en=1, inc_hr=0, inc_min=0, field_sel=00, blink=0, all counters 0. Reset mid-hold or mid-repeat discards the pending repeat.
- States: RUN, SET_HR, SET_MIN. mode_down: RUN->SET_HR, SET_HR->SET_MIN, SET_MIN->RUN. The transition is visible on field_sel/run_en the cycle after mode_down.
- run_en=1 only in RUN. On entering any state, the hold, repeat, blink and idle counters clear and blink=0.
- RUN: adj_down and adj_state are ignored. No inc pulses.
- Set states, single press: adj_down -> inc_hr (SET_HR) or inc_min (SET_MIN) high for exactly one cycle, on the cycle after adj_down. Latency 1.
- Auto-repeat: after adj_down, hold counter counts each cycle adj_state=1. When it reaches HOLD_CYCLES, one inc pulse is issued. Further pulses follow every REPEAT_CYCLES while adj_state stays 1. adj_state=0 clears hold and repeat counters immediately; no further pulses.
- An adj_state high without a preceding adj_down in the current state never repeats. This covers a button already held when mode was pressed.
- Simultaneous mode_down and adj_down: mode wins. The state advances and the adj event is dropped (no inc pulse).
- Idle timeout: the idle counter clears on adj_down, on mode_down, on any inc pulse, and while adj_state=1. Otherwise it increments in set states. At TIMEOUT_CYCLES the FSM goes to RUN with the same output effects as a mode-driven return.
- Blink: in set states, toggles every BLINK_CYCLES, starting at 0 on state entry. It is forced to 0 during any cycle an inc pulse is issued and its counter restarts, so the value being changed stays visible. It is 0 in RUN.
- Counter widths: $clog2(param+1). Counters saturate rather than wrap if a compare is missed; this cannot happen in a correct implementation and is asserted in the bench.
- inc_hr and inc_min are never high together. Neither is high in RUN.

Decomposition:
- Shared package (clock_pkg): state encoding constants ST_RUN=2'b00, ST_SET_HR=2'b01, ST_SET_MIN=2'b10. field_sel equals the state encoding directly.
- One sub-module, cycle_timer: a parameterised up-counter with clear, enable and a terminal-count pulse. It is instantiated four times: hold, repeat, blink and idle.
- The FSM and output registers live in set_mode_ctrl.

Test Plan:
All scenarios use HOLD=8, REPEAT=4, BLINK=3, TIMEOUT=40.
- Reset: rst=1 for 2 cycles in SET_MIN with adj held -> next cycle run_en=1, field_sel=00, blink=0, no inc pulse for 20 cycles after release.
- Mode cycling: three mode_down pulses 5 cycles apart -> field_sel 01, 10, 00, each one cycle after its pulse; run_en low only between the first and third.
- Single press in SET_HR: adj_down with adj_state high 3 cycles -> exactly one inc_hr, on the cycle after adj_down; inc_min stays 0.
- Auto-repeat in SET_MIN: adj_down then adj_state held 24 cycles -> inc_min pulses at 1, 8, 12, 16, 20 and 24 cycles after adj_down; release -> none after.
- Collision: mode_down and adj_down in the same cycle in SET_HR -> field_sel=10 next cycle, no inc_hr or inc_min.
- Timeout and blink: enter SET_HR with no input -> blink toggles every 3 cycles; field_sel=00 and run_en=1 after 40 idle cycles; an adj_down at idle cycle 30 delays the return by 30 cycles.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the clock time-set controller: mode state encoding
// and the mode-button step order.
package clock_pkg;

  // field_sel is driven straight from the state register, so the encoding is fixed.
  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10
  } state_e;

  function automatic state_e next_mode(input state_e s);
    case (s)
      ST_RUN:     return ST_SET_HR;
      ST_SET_HR:  return ST_SET_MIN;
      default:    return ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/set_mode_ctrl_if.sv
// Button-event inputs and counter/display command outputs of set_mode_ctrl.
// The master drives the debounced events; the slave is the controller.
interface set_mode_ctrl_if;
  logic       mode_down;
  logic       adj_state;
  logic       adj_down;
  logic       run_en;
  logic       inc_hr;
  logic       inc_min;
  logic [1:0] field_sel;
  logic       blink;

  modport master (
    output mode_down, adj_state, adj_down,
    input  run_en, inc_hr, inc_min, field_sel, blink
  );

  modport slave (
    input  mode_down, adj_state, adj_down,
    output run_en, inc_hr, inc_min, field_sel, blink
  );
endinterface

// File: rtl/set_mode_ctrl_cycle_timer.sv
// Up-counter with clear and enable. tc pulses on the enabled cycle that
// completes MAX counts, and the count restarts from zero on that same cycle.
module cycle_timer #(
  parameter int unsigned MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int unsigned W = $clog2(MAX + 1);
  localparam logic [W-1:0] LAST = W'(MAX - 1);
  localparam logic [W-1:0] TOP  = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d, base;

  // NOTE: every signal driven here gets a value before any branch, so no latch is inferred.
  always_comb begin
    base  = clr ? '0 : cnt_q;
    tc    = en && (base == LAST);
    cnt_d = base;
    if (en) begin
      if (base == LAST)     cnt_d = '0;
      else if (base >= TOP) cnt_d = TOP;
      else                  cnt_d = base + 1'b1;
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/set_mode_ctrl.sv
// Time-set sequencer: walks RUN -> SET_HR -> SET_MIN -> RUN on mode presses and
// issues single-cycle hour/minute increments with hold-to-repeat, idle timeout and blink.
module set_mode_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 50_000_000,
  parameter int unsigned REPEAT_CYCLES  = 12_500_000,
  parameter int unsigned BLINK_CYCLES   = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic           clk,
  input  logic           rst,
  set_mode_ctrl_if.slave bus
);

  state_e state_q, state_d;
  logic   run_en_q, run_en_d;
  logic   inc_hr_q, inc_hr_d;
  logic   inc_min_q, inc_min_d;
  logic   blink_q, blink_d;
  logic   armed_q, armed_d;
  logic   repeating_q, repeating_d;

  logic in_set, leave, adj_evt, inc_evt;
  logic hold_clr, hold_en, hold_tc;
  logic rep_clr, rep_en, rep_tc;
  logic blink_clr, blink_en, blink_tc;
  logic idle_clr, idle_en, idle_tc;

  assign in_set = (state_q == ST_SET_HR) || (state_q == ST_SET_MIN);

  // Every inc pulse coincides with adj_down or adj_state high, so clearing on
  // those inputs also clears on inc pulses and keeps the timeout path loop-free.
  assign idle_clr = !in_set || bus.mode_down || bus.adj_down || bus.adj_state;
  assign idle_en  = in_set && !idle_clr;

  assign leave   = bus.mode_down || (in_set && idle_tc);
  assign adj_evt = in_set && bus.adj_down && !leave;

  // Hold phase: only armed by an adj_down seen in this state.
  assign hold_en  = in_set && !leave && bus.adj_state && (adj_evt || armed_q);
  assign hold_clr = !in_set || leave || adj_evt || !bus.adj_state;

  assign rep_en   = in_set && !leave && bus.adj_state && repeating_q && !adj_evt;
  assign rep_clr  = !repeating_q || leave || adj_evt || !bus.adj_state;

  assign inc_evt  = adj_evt || hold_tc || rep_tc;

  assign blink_en  = in_set && !leave && !inc_evt;
  assign blink_clr = !in_set || leave || inc_evt;

  cycle_timer #(.MAX(HOLD_CYCLES)) u_hold_timer (
    .clk (clk), .rst (rst), .clr (hold_clr), .en (hold_en), .tc (hold_tc)
  );

  cycle_timer #(.MAX(REPEAT_CYCLES)) u_rep_timer (
    .clk (clk), .rst (rst), .clr (rep_clr), .en (rep_en), .tc (rep_tc)
  );

  cycle_timer #(.MAX(BLINK_CYCLES)) u_blink_timer (
    .clk (clk), .rst (rst), .clr (blink_clr), .en (blink_en), .tc (blink_tc)
  );

  cycle_timer #(.MAX(TIMEOUT_CYCLES)) u_idle_timer (
    .clk (clk), .rst (rst), .clr (idle_clr), .en (idle_en), .tc (idle_tc)
  );

  always_comb begin
    state_d = state_q;
    if (in_set && idle_tc)  state_d = ST_RUN;
    else if (bus.mode_down) state_d = next_mode(state_q);

    armed_d     = hold_en && !hold_tc;
    repeating_d = in_set && !leave && bus.adj_state && !adj_evt && (repeating_q || hold_tc);

    run_en_d  = (state_d == ST_RUN);
    inc_hr_d  = inc_evt && (state_q == ST_SET_HR);
    inc_min_d = inc_evt && (state_q == ST_SET_MIN);

    // The field being adjusted is always shown on the cycle it changes.
    blink_d = blink_q;
    if (!in_set || leave || inc_evt) blink_d = 1'b0;
    else if (blink_tc)               blink_d = !blink_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      run_en_q    <= 1'b1;
      inc_hr_q    <= 1'b0;
      inc_min_q   <= 1'b0;
      blink_q     <= 1'b0;
      armed_q     <= 1'b0;
      repeating_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_en_q    <= run_en_d;
      inc_hr_q    <= inc_hr_d;
      inc_min_q   <= inc_min_d;
      blink_q     <= blink_d;
      armed_q     <= armed_d;
      repeating_q <= repeating_d;
    end
  end

  assign bus.run_en    = run_en_q;
  assign bus.inc_hr    = inc_hr_q;
  assign bus.inc_min   = inc_min_q;
  assign bus.field_sel = state_q;
  assign bus.blink     = blink_q;

endmodule

// File: tb/tb_set_mode_ctrl.sv
// Directed bench for set_mode_ctrl with short timer parameters; table-driven
// vectors plus hand-written auto-repeat and timeout sequences.
module tb_set_mode_ctrl;
  localparam int unsigned HOLD    = 8;
  localparam int unsigned REPEAT  = 4;
  localparam int unsigned BLINK   = 3;
  localparam int unsigned TIMEOUT = 40;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   inv_err = 0;

  set_mode_ctrl_if bus();

  set_mode_ctrl #(
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (REPEAT),
    .BLINK_CYCLES   (BLINK),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Row: inputs held for one cycle; exp = {run_en, inc_hr, inc_min, field_sel, blink} after the edge.
  typedef struct {
    string      name;
    logic       rst;
    logic       md;
    logic       as;
    logic       ad;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input int n, input logic r, md, as, ad,
                     input logic run, ih, im, input logic [1:0] fs, input logic bl);
    vec_t v;
    v.name = name; v.rst = r; v.md = md; v.as = as; v.ad = ad;
    v.exp  = {run, ih, im, fs, bl};
    repeat (n) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, md, as, ad);
    rst           = r;
    bus.mode_down = md;
    bus.adj_state = as;
    bus.adj_down  = ad;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] outs();
    return {bus.run_en, bus.inc_hr, bus.inc_min, bus.field_sel, bus.blink};
  endfunction

  // Structural invariants and counter-saturation watch, sampled away from the edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if ((bus.inc_hr && bus.inc_min) || (bus.field_sel == 2'b11) ||
          ((bus.field_sel == 2'b00) && (bus.inc_hr || bus.inc_min)) ||
          (bus.run_en != (bus.field_sel == 2'b00)) ||
          (int'(dut.u_hold_timer.cnt_q)  >= int'(HOLD))   ||
          (int'(dut.u_rep_timer.cnt_q)   >= int'(REPEAT)) ||
          (int'(dut.u_blink_timer.cnt_q) >= int'(BLINK))  ||
          (int'(dut.u_idle_timer.cnt_q)  >= int'(TIMEOUT))) begin
        if (inv_err == 0) $display("invariant broken at t=%0t", $time);
        inv_err++;
      end
    end
  end

  task automatic run_timeout(input bit with_adj);
    int ret;
    int base;
    int j;
    logic [5:0] exp;
    ret = with_adj ? 70 : 40;
    for (int r = 0; r <= ret + 2; r++) begin
      drive(1'b0, r == 0, with_adj && (r == 30), with_adj && (r == 30));
      if (r < ret) begin
        base = (with_adj && r >= 30) ? 30 : 0;
        j    = r - base;
        exp  = {1'b0, with_adj && (r == 30), 1'b0, 2'b01, ((j / 3) % 2) != 0};
      end else begin
        exp  = 6'b100000;
      end
      check($sformatf("timeout%0d[%0d]", with_adj, r), outs(), exp);
    end
  endtask

  initial begin
    logic pulse;

    rst = 1'b1; bus.mode_down = 1'b0; bus.adj_state = 1'b0; bus.adj_down = 1'b0;

    //            name          n  rst md as ad   run ih im fs     bl
    add("reset",        2, 1, 0, 0, 0,   1, 0, 0, 2'b00, 0);
    add("run_idle",     2, 0, 0, 0, 0,   1, 0, 0, 2'b00, 0);
    add("mode1",        1, 0, 1, 0, 0,   0, 0, 0, 2'b01, 0);
    add("hr_blink0",    2, 0, 0, 0, 0,   0, 0, 0, 2'b01, 0);
    add("hr_blink1",    2, 0, 0, 0, 0,   0, 0, 0, 2'b01, 1);
    add("mode2",        1, 0, 1, 0, 0,   0, 0, 0, 2'b10, 0);
    add("min_blink0",   2, 0, 0, 0, 0,   0, 0, 0, 2'b10, 0);
    add("min_blink1",   2, 0, 0, 0, 0,   0, 0, 0, 2'b10, 1);
    add("mode3",        1, 0, 1, 0, 0,   1, 0, 0, 2'b00, 0);
    add("run_back",     1, 0, 0, 0, 0,   1, 0, 0, 2'b00, 0);
    add("to_hr",        1, 0, 1, 0, 0,   0, 0, 0, 2'b01, 0);
    add("to_min",       1, 0, 1, 0, 0,   0, 0, 0, 2'b10, 0);
    add("min_held",     1, 0, 0, 1, 0,   0, 0, 0, 2'b10, 0);
    add("rst_held",     2, 1, 0, 1, 0,   1, 0, 0, 2'b00, 0);
    add("post_rst",    20, 0, 0, 1, 0,   1, 0, 0, 2'b00, 0);
    add("run_adj",      1, 0, 0, 1, 1,   1, 0, 0, 2'b00, 0);
    add("run_rel",      1, 0, 0, 0, 0,   1, 0, 0, 2'b00, 0);
    add("sp_mode",      1, 0, 1, 0, 0,   0, 0, 0, 2'b01, 0);
    add("sp_press",     1, 0, 0, 1, 1,   0, 1, 0, 2'b01, 0);
    add("sp_hold",      2, 0, 0, 1, 0,   0, 0, 0, 2'b01, 0);
    add("sp_release",   1, 0, 0, 0, 0,   0, 0, 0, 2'b01, 1);
    add("collision",    1, 0, 1, 1, 1,   0, 0, 0, 2'b10, 0);
    add("coll_after",   1, 0, 0, 0, 0,   0, 0, 0, 2'b10, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].md, vecs[i].as, vecs[i].ad);
      check($sformatf("%s[%0d]", vecs[i].name, i), outs(), vecs[i].exp);
    end

    // Auto-repeat in SET_MIN: pulses 1, 8, 12, 16, 20, 24 cycles after adj_down.
    for (int k = 0; k < 40; k++) begin
      drive(1'b0, 1'b0, k < 24, k == 0);
      pulse = (k == 0) || (k == 7) || (k == 11) || (k == 15) || (k == 19) || (k == 23);
      check($sformatf("repeat[%0d]", k), {bus.inc_hr, bus.inc_min, bus.field_sel},
            {1'b0, pulse, 2'b10});
      if (pulse) check($sformatf("repeat_blink[%0d]", k), bus.blink, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("repeat_exit", outs(), 6'b100000);

    run_timeout(1'b0);
    run_timeout(1'b1);

    check("invariants", inv_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
